jtdd_sdram_sched: RTL and testbench

Round-robin scheduler that shares the single SDRAM read port among the game's ROM requesters: main CPU, sound CPU, MCU, ADPCM, and the char/scroll/object video fetchers. It sits between the per-slot ROM caches and the SDRAM controller. Each transaction is a single 32-bit read, and the result is steered back to the granted slot with a one-cycle completion pulse. During download it parks, and it enables refresh whenever the port is idle.

---
 rtl/jtdd_sdram_sched.sv | 146 ++++++++++++++
 tb/tb_jtdd_sdram_sched.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtdd_sdram_sched.sv
`default_nettype none
// ============================================================================
// Module   : jtdd_sdram_sched
// Purpose  : Round-robin arbiter sharing one SDRAM read port among ROM slots.
// Revision : 1.0
// ============================================================================
module jtdd_sdram_sched #(
    parameter int SLOTS = 4,
    parameter int AW    = 22,
    parameter int DW    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  downloading,
    input  logic [SLOTS-1:0]      slot_req,
    input  logic [SLOTS*AW-1:0]   slot_addr,
    output logic [SLOTS-1:0]      slot_done,
    output logic [DW-1:0]         slot_dout,
    output logic                  sdram_req,
    output logic [AW-1:0]         sdram_addr,
    input  logic                  sdram_ack,
    input  logic                  data_rdy,
    input  logic [DW-1:0]         data_read,
    output logic                  refresh_en,
    output logic                  busy
);

    localparam int GW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ACK  = 2'd1,
        ST_WAIT_DATA = 2'd2
    } state_t;

    state_t          state_q,      state_d;
    logic [GW-1:0]   grant_q,      grant_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic            sdram_req_q,  sdram_req_d;
    logic [AW-1:0]   sdram_addr_q, sdram_addr_d;
    logic [SLOTS-1:0] slot_done_q, slot_done_d;
    logic [DW-1:0]   slot_dout_q,  slot_dout_d;

    logic            pick_found;
    logic [GW-1:0]   pick_slot;
    logic [AW-1:0]   pick_addr;
    logic            grant_now;
    int              idx;

    // First requester above the last served slot, wrapping around
    always_comb begin
        pick_found = 1'b0;
        pick_slot  = '0;
        pick_addr  = '0;
        idx        = 0;
        for (int k = 1; k <= SLOTS; k++) begin
            idx = (int'(last_grant_q) + k) % SLOTS;
            if (!pick_found && slot_req[idx]) begin
                pick_found = 1'b1;
                pick_slot  = GW'(idx);
                pick_addr  = slot_addr[idx*AW +: AW];
            end
        end
    end

    // No grant can be issued while reset holds the flops
    assign grant_now = (state_q == ST_IDLE) && !downloading && pick_found && !rst;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        sdram_req_d  = sdram_req_q;
        sdram_addr_d = sdram_addr_q;
        slot_done_d  = '0;
        slot_dout_d  = slot_dout_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_now) begin
                    grant_d      = pick_slot;
                    sdram_addr_d = pick_addr;
                    sdram_req_d  = 1'b1;
                    state_d      = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                // An accepted request must finish, so ack outranks a download abort
                if (sdram_ack) begin
                    sdram_req_d = 1'b0;
                    if (data_rdy) begin
                        slot_dout_d          = data_read;
                        slot_done_d[grant_q] = 1'b1;
                        last_grant_d         = grant_q;
                        state_d              = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_DATA;
                    end
                end else if (downloading) begin
                    sdram_req_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            ST_WAIT_DATA: begin
                if (data_rdy) begin
                    slot_dout_d          = data_read;
                    slot_done_d[grant_q] = 1'b1;
                    last_grant_d         = grant_q;
                    state_d              = ST_IDLE;
                end
            end
            default: begin
                sdram_req_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(SLOTS - 1);
            sdram_req_q  <= 1'b0;
            sdram_addr_q <= '0;
            slot_done_q  <= '0;
            slot_dout_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            sdram_req_q  <= sdram_req_d;
            sdram_addr_q <= sdram_addr_d;
            slot_done_q  <= slot_done_d;
            slot_dout_q  <= slot_dout_d;
        end
    end

    assign slot_done  = slot_done_q;
    assign slot_dout  = slot_dout_q;
    assign sdram_req  = sdram_req_q;
    assign sdram_addr = sdram_addr_q;
    assign busy       = (state_q != ST_IDLE);
    assign refresh_en = downloading || rst || ((state_q == ST_IDLE) && !grant_now);

endmodule
`default_nettype wire

// File: tb/tb_jtdd_sdram_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtdd_sdram_sched
// Purpose  : Scoreboard bench with a small SDRAM controller model.
// Revision : 1.0
// ============================================================================
module tb_jtdd_sdram_sched;

    localparam int SLOTS = 4;
    localparam int AW    = 22;
    localparam int DW    = 32;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                downloading = 1'b0;
    logic [SLOTS-1:0]    slot_req = '0;
    logic [SLOTS*AW-1:0] slot_addr = '0;
    logic [SLOTS-1:0]    slot_done;
    logic [DW-1:0]       slot_dout;
    logic                sdram_req;
    logic [AW-1:0]       sdram_addr;
    logic                sdram_ack = 1'b0;
    logic                data_rdy = 1'b0;
    logic [DW-1:0]       data_read = '0;
    logic                refresh_en;
    logic                busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [SLOTS+DW-1:0] sb_q[$];

    jtdd_sdram_sched #(.SLOTS(SLOTS), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .downloading(downloading),
        .slot_req   (slot_req),
        .slot_addr  (slot_addr),
        .slot_done  (slot_done),
        .slot_dout  (slot_dout),
        .sdram_req  (sdram_req),
        .sdram_addr (sdram_addr),
        .sdram_ack  (sdram_ack),
        .data_rdy   (data_rdy),
        .data_read  (data_read),
        .refresh_en (refresh_en),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Completion monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (slot_done !== '0) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(slot_done), 32'(0));
            end else begin
                logic [SLOTS+DW-1:0] e;
                e = sb_q.pop_front();
                check("done_slot", 32'(slot_done), 32'(e[SLOTS+DW-1:DW]));
                check("done_data", slot_dout, e[DW-1:0]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        int t;
        t = 0;
        while (sdram_req !== 1'b1 && t < 20) begin
            step();
            t++;
        end
        ok = (sdram_req === 1'b1);
        if (!ok) check("req_timeout", 32'(0), 32'(1));
    endtask

    // Controller model: ack after ack_dly cycles, data data_dly cycles after ack
    task automatic serve(input int ack_dly, input int data_dly, input logic [DW-1:0] d,
                         input logic [AW-1:0] exp_addr, input logic [SLOTS-1:0] exp_slot,
                         input logic [SLOTS-1:0] drop_mask);
        bit ok;
        wait_req(ok);
        if (!ok) return;
        check("addr_at_req", 32'(sdram_addr), 32'(exp_addr));
        sb_q.push_back({exp_slot, d});
        repeat (ack_dly) step();
        check("addr_hold", 32'(sdram_addr), 32'(exp_addr));
        check("req_hold", 32'(sdram_req), 32'(1));
        sdram_ack = 1'b1;
        if (data_dly == 0) begin
            data_rdy  = 1'b1;
            data_read = d;
        end
        step();
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        check("req_release", 32'(sdram_req), 32'(0));
        if (data_dly == 0) begin
            check("fast_done", 32'(slot_done), 32'(exp_slot));
        end else begin
            slot_req = slot_req & ~drop_mask;
            check("busy_wait_data", 32'(busy), 32'(1));
            repeat (data_dly - 1) step();
            data_rdy  = 1'b1;
            data_read = d;
            step();
            data_rdy  = 1'b0;
        end
        check("idle_after_done", 32'(busy), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        for (int i = 0; i < SLOTS; i++) slot_addr[i*AW +: AW] = AW'(22'h10_0000 + i * 22'h1000);

        // Reset values
        do_reset();
        check("rst_req", 32'(sdram_req), 32'(0));
        check("rst_addr", 32'(sdram_addr), 32'(0));
        check("rst_done", 32'(slot_done), 32'(0));
        check("rst_dout", slot_dout, 32'(0));
        check("rst_refresh", 32'(refresh_en), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));

        // Single read on slot 0
        slot_addr[0 +: AW] = 22'h05_0000;
        slot_req = 4'b0001;
        serve(2, 3, 32'hDEADBEEF, 22'h05_0000, 4'b0001, 4'b0000);
        slot_req = 4'b0000;
        step();
        check("done_one_cycle", 32'(slot_done), 32'(0));
        check("dout_held", slot_dout, 32'hDEADBEEF);
        check("idle_refresh", 32'(refresh_en), 32'(1));

        // All slots requesting: order 0,1,2,3,0,1
        do_reset();
        slot_addr[0 +: AW] = 22'h10_0000;
        slot_req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            int s;
            s = k % SLOTS;
            serve(1, 2, 32'hA000_0000 + 32'(k), AW'(22'h10_0000 + s * 22'h1000),
                  SLOTS'(1 << s), 4'b0000);
        end
        slot_req = 4'b0000;
        step();

        // Ack and data in the same cycle; also request-to-bus latency
        slot_req = 4'b0010;
        step();
        check("req_latency", 32'(sdram_req), 32'(1));
        check("busy_wait_ack", 32'(busy), 32'(1));
        check("refresh_off", 32'(refresh_en), 32'(0));
        serve(0, 0, 32'h1234_5678, 22'h10_1000, 4'b0010, 4'b0000);
        slot_req = 4'b0000;
        step();

        // Slot 2 withdraws during WAIT_DATA, then slot 3 follows
        slot_req = 4'b1100;
        serve(1, 3, 32'hCAFE_0002, 22'h10_2000, 4'b0100, 4'b0100);
        serve(0, 1, 32'hCAFE_0003, 22'h10_3000, 4'b1000, 4'b0000);
        slot_req = 4'b0000;
        step();

        // Download abort while waiting for ack
        slot_req = 4'b0001;
        wait_req(ok);
        downloading = 1'b1;
        step();
        check("dl_req_drop", 32'(sdram_req), 32'(0));
        check("dl_refresh", 32'(refresh_en), 32'(1));
        check("dl_busy", 32'(busy), 32'(0));
        for (int c = 0; c < 4; c++) begin
            step();
            check("dl_no_grant", 32'(sdram_req), 32'(0));
        end
        downloading = 1'b0;
        serve(1, 1, 32'h0BAD_F00D, 22'h10_0000, 4'b0001, 4'b0000);
        slot_req = 4'b0000;
        step();

        // Asynchronous reset in WAIT_DATA
        slot_req = 4'b0110;
        wait_req(ok);
        check("pre_rst_addr", 32'(sdram_addr), 32'(22'h10_1000));
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0;
        check("pre_rst_busy", 32'(busy), 32'(1));
        #2;
        rst = 1'b1;
        slot_req = 4'b0011;
        #1;
        check("arst_req", 32'(sdram_req), 32'(0));
        check("arst_addr", 32'(sdram_addr), 32'(0));
        check("arst_dout", slot_dout, 32'(0));
        check("arst_busy", 32'(busy), 32'(0));
        check("arst_refresh", 32'(refresh_en), 32'(1));
        step();
        rst = 1'b0;
        serve(1, 1, 32'h5555_AAAA, 22'h10_0000, 4'b0001, 4'b0000);
        slot_req = 4'b0000;
        repeat (3) step();

        check("sb_empty", 32'(sb_q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
